// File: rtl/branch_predictor_gshare_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the gshare branch predictor: default sizing,
// index/tag width helpers, the counter initial value and the BTB entry
// layout. Imported by the top level and the return-address stack.
// ---------------------------------------------------------------------------
package bp_pkg;

    // Default sizing of the predictor
    localparam int BP_BTB_ENTRIES = 64;
    localparam int BP_TAG_BITS    = 8;
    localparam int BP_BHT_ENTRIES = 256;
    localparam int BP_CTR_BITS    = 2;
    localparam int BP_GHR_BITS    = 8;
    localparam int BP_RAS_DEPTH   = 4;

    // Instructions are word aligned; the two low PC bits never index anything
    localparam int PC_ALIGN_BITS = 2;

    // Widest tag the entry layout can hold; narrower tags are zero-extended
    localparam int TAG_MAX_BITS = 30;

    // Stored target drops the two always-zero low bits
    localparam int TGT_BITS = 32 - PC_ALIGN_BITS;

    // Index width for a power-of-two table
    function automatic int idx_bits(input int entries);
        return $clog2(entries);
    endfunction

    // Weakly not-taken: MSB clear, all lower bits set
    function automatic int ctr_init(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [TAG_MAX_BITS-1:0] tag;
        logic [TGT_BITS-1:0]     target;
        logic                    uncond;
        logic                    ret;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare_if
// Bundle of every predictor signal except clock and reset.
//   Fetch side   : bp_enable, if_addr, id_stall, wb_flush
//   Resolve side : ex_addr, ex_target, ex_target_valid, ex_br_inst,
//                  ex_is_uncond, ex_br_taken, ex_is_call, ex_is_ret
//   Prediction   : id_target, id_target_taken
// master drives the pipeline side (core / bench), slave is the predictor.
// ---------------------------------------------------------------------------
interface branch_predictor_gshare_if;

    logic        bp_enable;
    logic [31:0] if_addr;
    logic        id_stall;
    logic        wb_flush;
    logic [31:0] ex_addr;
    logic [31:0] ex_target;
    logic        ex_target_valid;
    logic        ex_br_inst;
    logic        ex_is_uncond;
    logic        ex_br_taken;
    logic        ex_is_call;
    logic        ex_is_ret;
    logic [31:0] id_target;
    logic        id_target_taken;

    modport master (
        output bp_enable, if_addr, id_stall, wb_flush,
        output ex_addr, ex_target, ex_target_valid, ex_br_inst,
        output ex_is_uncond, ex_br_taken, ex_is_call, ex_is_ret,
        input  id_target, id_target_taken
    );

    modport slave (
        input  bp_enable, if_addr, id_stall, wb_flush,
        input  ex_addr, ex_target, ex_target_valid, ex_br_inst,
        input  ex_is_uncond, ex_br_taken, ex_is_call, ex_is_ret,
        output id_target, id_target_taken
    );

endinterface

// File: rtl/branch_predictor_gshare_ras.sv
// ---------------------------------------------------------------------------
// bp_ras
// Circular return-address stack updated from EX.
//   clk, rst_n : clock, asynchronous active-low reset (pointer/count only)
//   push       : store push_addr as the new top
//   pop        : discard the top (ignored when empty)
//   push_addr  : return address to store
//   top_addr   : current top of stack (meaningful only when !empty)
//   empty      : no valid entries
// push and pop together replace the top in place. When full, a push
// overwrites the oldest entry and the count stays at RAS_DEPTH.
// ---------------------------------------------------------------------------
module bp_ras
    import bp_pkg::*;
#(
    parameter int RAS_DEPTH = BP_RAS_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] top_addr,
    output logic        empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [31:0]      stack [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;     // next free slot; top is the one below
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] top_ptr;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    always_comb begin
        top_ptr    = wr_ptr - PTR_W'(1);
        // With nothing to replace, call+ret degenerates into a plain push
        do_replace = push && pop && (count != '0);
        do_push    = push && !do_replace;
        do_pop     = pop && !push && (count != '0);
    end

    assign top_addr = stack[top_ptr];
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (do_replace) begin
            stack[top_ptr] <= push_addr;
        end else if (do_push) begin
            stack[wr_ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            count  <= (count == CNT_FULL) ? count : count + CNT_W'(1);
        end else if (do_pop) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare
// Tagged BTB + gshare pattern table + return-address stack. Looks up the
// fetch PC every cycle and presents a registered prediction to ID one cycle
// later; trains non-speculatively from EX resolution.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : branch_predictor_gshare_if.slave
//                inputs  bp_enable, if_addr, id_stall, wb_flush, ex_*
//                outputs id_target, id_target_taken
// Output register priority: wb_flush (drop taken) > id_stall (hold) > load.
// Lookups always see table contents from before this cycle's training.
// ---------------------------------------------------------------------------
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int TAG_BITS    = BP_TAG_BITS,
    parameter int BHT_ENTRIES = BP_BHT_ENTRIES,
    parameter int CTR_BITS    = BP_CTR_BITS,
    parameter int GHR_BITS    = BP_GHR_BITS,
    parameter int RAS_DEPTH   = BP_RAS_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_predictor_gshare_if.slave  bus
);

    localparam int BTB_IDX_W = idx_bits(BTB_ENTRIES);
    localparam int BHT_IDX_W = idx_bits(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    // Saturating up/down counter step
    function automatic logic [CTR_BITS-1:0] ctr_sat_step(
        input logic [CTR_BITS-1:0] ctr,
        input logic                taken
    );
        if (taken) begin
            return (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTR_BITS'(1);
    endfunction

    btb_entry_t           btb [BTB_ENTRIES];
    logic [CTR_BITS-1:0]  bht [BHT_ENTRIES];
    logic [GHR_BITS-1:0]  ghr;

    logic [31:0]          ras_top;
    logic                 ras_empty;

    // ---- p0: table lookup on the fetch PC ----
    logic [BTB_IDX_W-1:0] btb_idx_p0;
    logic [TAG_BITS-1:0]  tag_p0;
    logic [BHT_IDX_W-1:0] bht_idx_p0;
    btb_entry_t           entry_p0;
    logic                 hit_p0;
    logic                 taken_p0;
    logic [31:0]          target_p0;

    always_comb begin
        btb_idx_p0 = bus.if_addr[PC_ALIGN_BITS +: BTB_IDX_W];
        tag_p0     = bus.if_addr[PC_ALIGN_BITS + BTB_IDX_W +: TAG_BITS];
        bht_idx_p0 = bus.if_addr[PC_ALIGN_BITS +: BHT_IDX_W] ^ BHT_IDX_W'(ghr);
        entry_p0   = btb[btb_idx_p0];
        hit_p0     = entry_p0.valid && (entry_p0.tag == TAG_MAX_BITS'(tag_p0));
        taken_p0   = bus.bp_enable && hit_p0 &&
                     (entry_p0.uncond || bht[bht_idx_p0][CTR_BITS-1]);
        target_p0  = (entry_p0.ret && !ras_empty) ? ras_top
                                                   : {entry_p0.target, 2'b00};
    end

    // ---- p1: registered prediction presented to ID ----
    logic [31:0] id_target_p1;
    logic        id_taken_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_target_p1 <= '0;
            id_taken_p1  <= 1'b0;
        end else if (bus.wb_flush) begin
            id_taken_p1  <= 1'b0;
        end else if (!bus.id_stall) begin
            id_taken_p1  <= taken_p0;
            id_target_p1 <= taken_p0 ? target_p0 : '0;
        end
    end

    assign bus.id_target       = id_target_p1;
    assign bus.id_target_taken = id_taken_p1;

    // ---- EX: training from resolved branches ----
    logic [BTB_IDX_W-1:0] btb_idx_ex;
    logic [TAG_BITS-1:0]  tag_ex;
    logic [BHT_IDX_W-1:0] bht_idx_ex;
    logic                 train_btb;
    logic                 train_bht;
    btb_entry_t           entry_ex;

    always_comb begin
        btb_idx_ex = bus.ex_addr[PC_ALIGN_BITS +: BTB_IDX_W];
        tag_ex     = bus.ex_addr[PC_ALIGN_BITS + BTB_IDX_W +: TAG_BITS];
        // History used here is the pre-update value, so a GHR that moved
        // since fetch can train a different counter than was read; accepted.
        bht_idx_ex = bus.ex_addr[PC_ALIGN_BITS +: BHT_IDX_W] ^ BHT_IDX_W'(ghr);
        train_btb  = bus.ex_br_inst && bus.ex_br_taken && bus.ex_target_valid;
        train_bht  = bus.ex_br_inst && !bus.ex_is_uncond;
        entry_ex   = '{valid:  1'b1,
                       tag:    TAG_MAX_BITS'(tag_ex),
                       target: bus.ex_target[31:PC_ALIGN_BITS],
                       uncond: bus.ex_is_uncond,
                       ret:    bus.ex_is_ret};
    end

    // Not-taken resolutions never touch the BTB; an existing entry survives
    // and only its counter decays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i] <= '0;
            end
        end else if (train_btb) begin
            btb[btb_idx_ex] <= entry_ex;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
            ghr <= '0;
        end else if (train_bht) begin
            bht[bht_idx_ex] <= ctr_sat_step(bht[bht_idx_ex], bus.ex_br_taken);
            if (GHR_BITS > 1) begin
                ghr <= {ghr[GHR_BITS-2:0], bus.ex_br_taken};
            end else begin
                ghr <= GHR_BITS'(bus.ex_br_taken);
            end
        end
    end

    bp_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.ex_br_inst && bus.ex_is_call),
        .pop       (bus.ex_br_inst && bus.ex_is_ret),
        .push_addr (bus.ex_addr + 32'd4),
        .top_addr  (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_gshare
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the predictor (plain arrays and a queue for the RAS).
// ---------------------------------------------------------------------------
module tb_branch_predictor_gshare;

    localparam int BTB_N    = 64;
    localparam int TAGW     = 8;
    localparam int BHT_N    = 256;
    localparam int CTRW     = 2;
    localparam int GHRW     = 8;
    localparam int RAS_N    = 4;
    localparam int CTR_TOP  = (1 << CTRW) - 1;
    localparam int CTR_MID  = 1 << (CTRW - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    branch_predictor_gshare_if bus ();

    branch_predictor_gshare #(
        .BTB_ENTRIES (BTB_N),
        .TAG_BITS    (TAGW),
        .BHT_ENTRIES (BHT_N),
        .CTR_BITS    (CTRW),
        .GHR_BITS    (GHRW),
        .RAS_DEPTH   (RAS_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_vld [BTB_N];
    int unsigned m_tag [BTB_N];
    logic [31:0] m_tgt [BTB_N];
    bit          m_unc [BTB_N];
    bit          m_ret [BTB_N];
    int          m_bht [BHT_N];
    int unsigned m_ghr;
    logic [31:0] m_ras [$];
    logic        exp_taken;
    logic [31:0] exp_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BTB_N; i++) begin
            m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_unc[i] = 0; m_ret[i] = 0;
        end
        for (int i = 0; i < BHT_N; i++) m_bht[i] = CTR_MID - 1;
        m_ghr = 0;
        m_ras.delete();
        exp_taken = 1'b0;
        exp_tgt   = '0;
    endtask

    function automatic int unsigned btb_slot(input logic [31:0] pc);
        return (pc >> 2) % BTB_N;
    endfunction

    function automatic int unsigned pc_tag(input logic [31:0] pc);
        return (pc >> 2) / BTB_N % (1 << TAGW);
    endfunction

    function automatic int unsigned bht_slot(input logic [31:0] pc);
        return ((pc >> 2) % BHT_N) ^ m_ghr;
    endfunction

    task automatic model_lookup(input logic [31:0] pc, input logic en,
                                output logic tk, output logic [31:0] tg);
        int unsigned s;
        bit hit;
        s   = btb_slot(pc);
        hit = m_vld[s] && (m_tag[s] == pc_tag(pc));
        tk  = en && hit && (m_unc[s] || (m_bht[bht_slot(pc)] >= CTR_MID));
        tg  = '0;
        if (tk) tg = (m_ret[s] && m_ras.size() > 0) ? m_ras[$] : m_tgt[s];
    endtask

    task automatic model_train(input logic [31:0] ea, input logic [31:0] et,
                               input bit unc, input bit tkn, input bit tv,
                               input bit call, input bit ret);
        int unsigned s, b;
        if (tkn && tv) begin
            s = btb_slot(ea);
            m_vld[s] = 1; m_tag[s] = pc_tag(ea); m_tgt[s] = et & 32'hFFFF_FFFC;
            m_unc[s] = unc; m_ret[s] = ret;
        end
        if (!unc) begin
            b = bht_slot(ea);
            if (tkn && m_bht[b] < CTR_TOP) m_bht[b]++;
            if (!tkn && m_bht[b] > 0) m_bht[b]--;
            m_ghr = ((m_ghr << 1) | int'(tkn)) % (1 << GHRW);
        end
        if (call && ret) begin
            if (m_ras.size() == 0) m_ras.push_back(ea + 32'd4);
            else m_ras[m_ras.size() - 1] = ea + 32'd4;
        end else if (call) begin
            m_ras.push_back(ea + 32'd4);
            if (m_ras.size() > RAS_N) void'(m_ras.pop_front());
        end else if (ret && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
    endtask

    // One clock: predict from the current inputs, advance the model across
    // the edge, then compare the registered outputs.
    task automatic cycle();
        logic tk;
        logic [31:0] tg;
        logic flush, stall, br;
        logic [31:0] ea, et;
        bit unc, tkn, tv, call, ret;
        model_lookup(bus.if_addr, bus.bp_enable, tk, tg);
        flush = bus.wb_flush; stall = bus.id_stall; br = bus.ex_br_inst;
        ea = bus.ex_addr; et = bus.ex_target; unc = bus.ex_is_uncond;
        tkn = bus.ex_br_taken; tv = bus.ex_target_valid;
        call = bus.ex_is_call; ret = bus.ex_is_ret;
        @(posedge clk);
        if (flush) exp_taken = 1'b0;
        else if (!stall) begin
            exp_taken = tk;
            exp_tgt   = tg;
        end
        if (br) model_train(ea, et, unc, tkn, tv, call, ret);
        #1;
        check("taken", 32'(bus.id_target_taken), 32'(exp_taken));
        check("target", bus.id_target, exp_tgt);
    endtask

    task automatic clear_ex();
        bus.ex_br_inst = 0; bus.ex_addr = '0; bus.ex_target = '0;
        bus.ex_target_valid = 0; bus.ex_is_uncond = 0; bus.ex_br_taken = 0;
        bus.ex_is_call = 0; bus.ex_is_ret = 0;
    endtask

    task automatic resolve(input logic [31:0] a, input logic [31:0] t,
                           input bit unc, input bit tkn, input bit call, input bit ret);
        bus.ex_br_inst = 1; bus.ex_addr = a; bus.ex_target = t;
        bus.ex_target_valid = 1; bus.ex_is_uncond = unc; bus.ex_br_taken = tkn;
        bus.ex_is_call = call; bus.ex_is_ret = ret;
        cycle();
        clear_ex();
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + 32'($urandom_range(0, 3) << 8) + 32'($urandom_range(0, 15) << 2);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ras_exp [5];
        ras_exp = '{32'h504, 32'h404, 32'h304, 32'h204, 32'h7000};

        bus.bp_enable = 1; bus.if_addr = 32'h4000_0000;
        bus.id_stall = 0; bus.wb_flush = 0;
        clear_ex();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_taken", 32'(bus.id_target_taken), 32'h0);
        check("rst_target", bus.id_target, 32'h0);
        rst_n = 1'b1;

        // Empty predictor: nothing is ever predicted taken
        for (logic [31:0] a = 32'h4000_0000; a <= 32'h4000_0100; a += 4) begin
            bus.if_addr = a;
            cycle();
            check("sweep_taken", 32'(bus.id_target_taken), 32'h0);
        end

        // Unconditional jump, with and without bp_enable
        resolve(32'h1000, 32'h2000, 1, 1, 0, 0);
        bus.if_addr = 32'h1000;
        cycle();
        check("jal_taken", 32'(bus.id_target_taken), 32'h1);
        check("jal_target", bus.id_target, 32'h2000);
        bus.bp_enable = 0;
        cycle();
        check("dis_taken", 32'(bus.id_target_taken), 32'h0);
        bus.bp_enable = 1;

        // Conditional branch training T,T,N,N,N with a lookup after each
        foreach (ras_exp[k]) begin
            bus.if_addr = 32'h4000_0000;
            resolve(32'h1040, 32'h1080, 0, (k < 2), 0, 0);
            bus.if_addr = 32'h1040;
            cycle();
        end

        // Return-address stack: ret trained on an empty stack, five calls,
        // then alternate lookups of the ret with its resolution
        bus.if_addr = 32'h4000_0000;
        resolve(32'h908, 32'h7000, 1, 1, 0, 1);
        for (int i = 1; i <= 5; i++) resolve(32'(i * 32'h100), 32'h8000, 1, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            bus.if_addr = 32'h908;
            cycle();
            check("ras_target", bus.id_target, ras_exp[k]);
            bus.if_addr = 32'h4000_0000;
            if (k < 4) resolve(32'h908, 32'h7000, 1, 1, 0, 1);
        end

        // Stall holds the registered prediction; flush beats stall
        resolve(32'h1000, 32'h2000, 1, 1, 0, 0);
        bus.if_addr = 32'h1000;
        cycle();
        bus.id_stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.if_addr = 32'h4000_0000 + 32'(i * 4);
            cycle();
            check("stall_target", bus.id_target, 32'h2000);
            check("stall_taken", 32'(bus.id_target_taken), 32'h1);
        end
        bus.wb_flush = 1;
        cycle();
        check("flush_taken", 32'(bus.id_target_taken), 32'h0);
        bus.wb_flush = 0; bus.id_stall = 0;

        // Same-cycle lookup and retrain of one entry sees the old target
        bus.if_addr = 32'h1000;
        resolve(32'h1000, 32'h3000, 1, 1, 0, 0);
        check("rbw_old", bus.id_target, 32'h2000);
        cycle();
        check("rbw_new", bus.id_target, 32'h3000);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_taken", 32'(bus.id_target_taken), 32'h0);
        check("arst_target", bus.id_target, 32'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        check("post_rst_taken", 32'(bus.id_target_taken), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int kind;
            bus.if_addr   = rand_pc();
            bus.bp_enable = ($urandom_range(0, 9) != 0);
            bus.id_stall  = ($urandom_range(0, 7) == 0);
            bus.wb_flush  = ($urandom_range(0, 9) == 0);
            clear_ex();
            if ($urandom_range(0, 9) < 6) begin
                kind = int'($urandom_range(0, 3));
                bus.ex_br_inst      = 1;
                bus.ex_addr         = rand_pc();
                bus.ex_target       = rand_pc();
                bus.ex_target_valid = ($urandom_range(0, 7) != 0);
                bus.ex_is_uncond    = (kind != 0);
                bus.ex_br_taken     = (kind != 0) || ($urandom_range(0, 1) == 1);
                bus.ex_is_call      = (kind == 1);
                bus.ex_is_ret       = (kind == 2) || (kind == 1 && $urandom_range(0, 7) == 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
